// File: rtl/ddr_test_pkg.sv
// Shared constants, FSM state type and default test pattern for the DDR read/write testers.
package ddr_test_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [2:0] AXSIZE_16B = 3'b100;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 32'h0000_F000;
  localparam logic [DATA_W-1:0] DEF_PATTERN   = 128'h0000_0000_0000_0000_1234_5678_8765_4321;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  // Data written/expected at a given beat of the burst (modular add).
  function automatic logic [DATA_W-1:0] beat_pattern(input logic [DATA_W-1:0] base,
                                                     input logic [LEN_W-1:0]  beat);
    return base + DATA_W'(beat);
  endfunction

endpackage

// File: rtl/ddr_ctr_rd_test_if.sv
// AXI4 read address/data channel bundle between the read tester and the DDR controller slave port.
interface ddr_ctr_rd_test_if;
  import ddr_test_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/ddr_rd_beat_checker.sv
// Compares each accepted R beat with the expected pattern and records error count and first failure.
module ddr_rd_beat_checker
  import ddr_test_pkg::*;
#(
  parameter int unsigned       BURST_LEN = 4,
  parameter logic [DATA_W-1:0] PATTERN   = DEF_PATTERN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_valid,
  input  logic [LEN_W-1:0]  beat,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [LEN_W-1:0]  err_beat,
  output logic [DATA_W-1:0] err_data
);

  localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [DATA_W-1:0] expected_c;
  logic              beat_err_c;

  // A beat counts as one error whether data, response or last flag is wrong.
  always_comb begin
    expected_c = beat_pattern(PATTERN, beat);
    beat_err_c = (rdata != expected_c) || (rresp != RESP_OKAY) || (rlast != (beat == LAST_BEAT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt  <= '0;
      err_beat <= '0;
      err_data <= '0;
    end else if (beat_valid && beat_err_c) begin
      if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
      if (err_cnt == '0) begin
        err_beat <= beat;
        err_data <= rdata;
      end
    end
  end

endmodule

// File: rtl/ddr_ctr_rd_test.sv
// AXI4 read-back tester: one burst at BASE_ADDR once DDR is ready, checks every beat, reports result.
// Build with DDR_RD_TEST_LOOP_EN defined to repeat the burst forever and expose iter_cnt.
module ddr_ctr_rd_test
  import ddr_test_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned       BURST_LEN = 4,
  parameter logic [DATA_W-1:0] PATTERN   = DEF_PATTERN,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ddr_ready,
  ddr_ctr_rd_test_if.master     axi,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [LEN_W-1:0]      err_beat,
  output logic [DATA_W-1:0]     err_data
`ifdef DDR_RD_TEST_LOOP_EN
  ,
  output logic [15:0]           iter_cnt
`endif
);

  localparam int unsigned      TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(BURST_LEN - 1);

  rd_state_e         state;
  logic [TMR_W-1:0]  timer;
  logic [LEN_W-1:0]  beat;
  logic              arvalid_q;
  logic              rready_q;
  logic              ar_fire_c;
  logic              r_fire_c;
`ifdef DDR_RD_TEST_LOOP_EN
  localparam logic [3:0] IDLE_LAST = 4'd15;
  logic [3:0]        idle_cnt;
`endif

  assign axi.araddr  = BASE_ADDR;
  assign axi.arlen   = LAST_BEAT;
  assign axi.arsize  = AXSIZE_16B;
  assign axi.arburst = BURST_INCR;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign ar_fire_c = arvalid_q & axi.arready;
  assign r_fire_c  = axi.rvalid & rready_q;

  ddr_rd_beat_checker #(
    .BURST_LEN (BURST_LEN),
    .PATTERN   (PATTERN)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .beat_valid (r_fire_c),
    .beat       (beat),
    .rdata      (axi.rdata),
    .rresp      (axi.rresp),
    .rlast      (axi.rlast),
    .err_cnt    (err_cnt),
    .err_beat   (err_beat),
    .err_data   (err_data)
  );

  // Control FSM; the timer watches for a stalled handshake in ADDR and DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      timer     <= '0;
      beat      <= '0;
`ifdef DDR_RD_TEST_LOOP_EN
      idle_cnt  <= '0;
      iter_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (ddr_ready) begin
            arvalid_q <= 1'b1;
            timer     <= '0;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ar_fire_c) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat      <= '0;
            timer     <= '0;
            state     <= ST_DATA;
          end else if (timer == TMR_MAX) begin
            arvalid_q <= 1'b0;
            timeout   <= 1'b1;
            state     <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_fire_c) begin
            beat  <= beat + 1'b1;
            timer <= '0;
            // An early rlast terminates the burst; the checker flags that beat.
            if (axi.rlast || (beat == LAST_BEAT)) begin
              rready_q <= 1'b0;
              state    <= ST_DONE;
            end
          end else if (timer == TMR_MAX) begin
            rready_q <= 1'b0;
            timeout  <= 1'b1;
            state    <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: begin
`ifdef DDR_RD_TEST_LOOP_EN
          // err_cnt and timeout accumulate, so pass falls permanently on any failing pass.
          done     <= (idle_cnt == '0);
          idle_cnt <= idle_cnt + 1'b1;
          if (idle_cnt == '0) begin
            pass     <= (err_cnt == '0) && !timeout;
            iter_cnt <= iter_cnt + 1'b1;
          end
          if (idle_cnt == IDLE_LAST) begin
            idle_cnt  <= '0;
            arvalid_q <= 1'b1;
            timer     <= '0;
            state     <= ST_ADDR;
          end
`else
          done <= 1'b1;
          pass <= (err_cnt == '0) && !timeout;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_ctr_rd_test.sv
// Randomized self-checking bench for ddr_ctr_rd_test against a burst-level reference model.
module tb_ddr_ctr_rd_test;
  import ddr_test_pkg::*;

  localparam int unsigned BL  = 4;
  localparam int unsigned TMO = 32;
  localparam logic [127:0] PAT  = 128'h0000_0000_0000_0000_1234_5678_8765_4321;
  localparam logic [31:0]  BASE = 32'h0000_F000;

  logic         clk = 1'b0;
  logic         rst;
  logic         ddr_ready;
  logic         done, pass, timeout;
  logic [7:0]   err_cnt, err_beat;
  logic [127:0] err_data;
`ifdef DDR_RD_TEST_LOOP_EN
  logic [15:0]  iter_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-beat slave response table and model results
  logic [127:0] bd [BL];
  logic [1:0]   br [BL];
  logic         bl [BL];
  int           n_acc;
  int           m_cnt, m_beat;
  logic [127:0] m_data;
  logic         m_pass;

  ddr_ctr_rd_test_if axi();

  ddr_ctr_rd_test #(
    .BASE_ADDR (BASE),
    .BURST_LEN (BL),
    .PATTERN   (PAT),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ddr_ready (ddr_ready),
    .axi       (axi),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .err_cnt   (err_cnt),
    .err_beat  (err_beat),
    .err_data  (err_data)
`ifdef DDR_RD_TEST_LOOP_EN
    ,
    .iter_cnt  (iter_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_clean();
    for (int i = 0; i < BL; i++) begin
      bd[i] = PAT + 128'(i);
      br[i] = 2'b00;
      bl[i] = (i == BL - 1);
    end
  endtask

  // Slave stops after its rlast; the tester stops after BL beats at most.
  task automatic run_model();
    n_acc = BL;
    for (int i = 0; i < BL; i++) if (bl[i]) begin n_acc = i + 1; break; end
    m_cnt = 0; m_beat = 0; m_data = '0;
    for (int i = 0; i < n_acc; i++) begin
      logic [127:0] want;
      want = PAT + 128'(i);
      if (bd[i] != want || br[i] != 2'b00 || bl[i] != (i == BL - 1)) begin
        if (m_cnt == 0) begin m_beat = i; m_data = bd[i]; end
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_pass = (m_cnt == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; ddr_ready = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Plays one burst from IDLE using the response table; reports handshake/latency observations.
  task automatic drive_burst(input int ar_delay, output bit ar_ok, output bit rdy_ok, output bit lat_ok);
    ar_ok = 1'b1; rdy_ok = 1'b1; lat_ok = 1'b1;
    ddr_ready = 1'b1;
    @(posedge clk); #1;
    if (axi.arvalid !== 1'b1) ar_ok = 1'b0;
    ddr_ready = 1'($urandom_range(0, 1));
    repeat (ar_delay) begin
      @(posedge clk); #1;
      if (axi.arvalid !== 1'b1) ar_ok = 1'b0;
    end
    axi.arready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b0;
    if (axi.arvalid !== 1'b0) ar_ok = 1'b0;
    for (int i = 0; i < n_acc; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      axi.rvalid = 1'b1; axi.rdata = bd[i]; axi.rresp = br[i]; axi.rlast = bl[i];
      if (axi.rready !== 1'b1) rdy_ok = 1'b0;
      @(posedge clk); #1;
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
    end
    if (done !== 1'b0 || axi.rready !== 1'b0) lat_ok = 1'b0;
    @(posedge clk); #1;
    if (done !== 1'b1) lat_ok = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (axi.arvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_arvalid got %b want 0", axi.arvalid); end
    tests_run++; if (axi.rready !== 1'b0) begin tests_failed++; $display("FAIL reset_rready got %b want 0", axi.rready); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL reset_pass got %b want 0", pass); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got %b want 0", timeout); end
    tests_run++; if (err_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    tests_run++; if (err_beat !== 8'd0) begin tests_failed++; $display("FAIL reset_err_beat got %0d want 0", err_beat); end
    tests_run++; if (err_data !== 128'd0) begin tests_failed++; $display("FAIL reset_err_data got %h want 0", err_data); end
    repeat (3) @(posedge clk); #1;
    tests_run++; if (axi.arvalid !== 1'b0) begin tests_failed++; $display("FAIL idle_no_ready got arvalid %b want 0", axi.arvalid); end
  endtask

  task automatic test_normal();
    bit ar_ok, rdy_ok, lat_ok;
    do_reset(); set_clean(); run_model();
    tests_run++; if (axi.araddr !== BASE) begin tests_failed++; $display("FAIL araddr got %h want %h", axi.araddr, BASE); end
    tests_run++; if (axi.arlen !== 8'(BL - 1)) begin tests_failed++; $display("FAIL arlen got %0d want %0d", axi.arlen, BL - 1); end
    tests_run++; if (axi.arsize !== 3'b100) begin tests_failed++; $display("FAIL arsize got %b want 100", axi.arsize); end
    tests_run++; if (axi.arburst !== 2'b01) begin tests_failed++; $display("FAIL arburst got %b want 01", axi.arburst); end
    drive_burst(2, ar_ok, rdy_ok, lat_ok);
    tests_run++; if (!ar_ok) begin tests_failed++; $display("FAIL normal_ar_handshake got bad arvalid sequence want ok"); end
    tests_run++; if (!rdy_ok) begin tests_failed++; $display("FAIL normal_rready got low during burst want high"); end
    tests_run++; if (!lat_ok) begin tests_failed++; $display("FAIL normal_done_latency got wrong done timing want 1 cycle after last beat"); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL normal_pass got %b want 1", pass); end
    tests_run++; if (err_cnt !== 8'd0) begin tests_failed++; $display("FAIL normal_err_cnt got %0d want 0", err_cnt); end
    repeat (5) @(posedge clk); #1;
    tests_run++; if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0) begin tests_failed++; $display("FAIL normal_sticky got done %b pass %b timeout %b want 1 1 0", done, pass, timeout); end
  endtask

  // Directed single-fault bursts: 0 = data mismatch beat 2, 1 = bad resp beat 0, 2 = early rlast beat 1
  task automatic test_directed_faults();
    bit ar_ok, rdy_ok, lat_ok;
    for (int k = 0; k < 3; k++) begin
      do_reset(); set_clean();
      case (k)
        0: bd[2] = '0;
        1: br[0] = 2'b10;
        default: bl[1] = 1'b1;
      endcase
      run_model();
      drive_burst(k, ar_ok, rdy_ok, lat_ok);
      tests_run++; if (!lat_ok || !rdy_ok) begin tests_failed++; $display("FAIL fault%0d_exit got lat %b rdy %b want 1 1", k, lat_ok, rdy_ok); end
      tests_run++; if (err_cnt !== 8'(m_cnt)) begin tests_failed++; $display("FAIL fault%0d_err_cnt got %0d want %0d", k, err_cnt, m_cnt); end
      tests_run++; if (err_beat !== 8'(m_beat)) begin tests_failed++; $display("FAIL fault%0d_err_beat got %0d want %0d", k, err_beat, m_beat); end
      tests_run++; if (err_data !== m_data) begin tests_failed++; $display("FAIL fault%0d_err_data got %h want %h", k, err_data, m_data); end
      tests_run++; if (pass !== 1'b0 || done !== 1'b1) begin tests_failed++; $display("FAIL fault%0d_result got pass %b done %b want 0 1", k, pass, done); end
    end
  endtask

  task automatic test_random();
    bit ar_ok, rdy_ok, lat_ok;
    for (int it = 0; it < 20; it++) begin
      do_reset(); set_clean();
      for (int i = 0; i < BL; i++) begin
        if ($urandom_range(0, 2) == 0) bd[i] = bd[i] ^ (128'd1 << $urandom_range(0, 127));
        if ($urandom_range(0, 3) == 0) br[i] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 5) == 0) bl[i] = ~bl[i];
      end
      run_model();
      drive_burst(int'($urandom_range(0, 4)), ar_ok, rdy_ok, lat_ok);
      tests_run++;
      if (!ar_ok || !rdy_ok || !lat_ok || err_cnt !== 8'(m_cnt) || pass !== m_pass
          || (m_cnt != 0 && (err_beat !== 8'(m_beat) || err_data !== m_data))) begin
        tests_failed++;
        $display("FAIL random%0d got cnt %0d beat %0d pass %b hs %b%b%b want cnt %0d beat %0d pass %b hs 111",
                 it, err_cnt, err_beat, pass, ar_ok, rdy_ok, lat_ok, m_cnt, m_beat, m_pass);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    ddr_ready = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    while (axi.arvalid && cnt < 200) begin cnt++; @(posedge clk); #1; end
    tests_run++; if (cnt != TMO) begin tests_failed++; $display("FAIL tmo_addr_cycles got %0d want %0d", cnt, TMO); end
    tests_run++; if (timeout !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL tmo_addr_flag got timeout %b done %b want 1 0", timeout, done); end
    @(posedge clk); #1;
    tests_run++; if (done !== 1'b1 || pass !== 1'b0 || axi.arvalid !== 1'b0) begin tests_failed++; $display("FAIL tmo_addr_done got done %b pass %b arvalid %b want 1 0 0", done, pass, axi.arvalid); end
    // Stall on the data channel after a good address handshake
    do_reset();
    ddr_ready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b0;
    cnt = 0;
    while (axi.rready && cnt < 200) begin cnt++; @(posedge clk); #1; end
    tests_run++; if (cnt != TMO) begin tests_failed++; $display("FAIL tmo_data_cycles got %0d want %0d", cnt, TMO); end
    @(posedge clk); #1;
    tests_run++; if (timeout !== 1'b1 || done !== 1'b1 || pass !== 1'b0) begin tests_failed++; $display("FAIL tmo_data_done got timeout %b done %b pass %b want 1 1 0", timeout, done, pass); end
  endtask

  task automatic test_reset_mid_data();
    bit ar_ok, rdy_ok, lat_ok;
    do_reset(); set_clean();
    bd[0] = ~bd[0];
    ddr_ready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axi.rvalid = 1'b1; axi.rdata = bd[i]; axi.rresp = br[i]; axi.rlast = bl[i];
      @(posedge clk); #1;
    end
    axi.rvalid = 1'b0;
    tests_run++; if (err_cnt !== 8'd1) begin tests_failed++; $display("FAIL mid_pre_err_cnt got %0d want 1", err_cnt); end
    rst = 1'b1; ddr_ready = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0
        || err_cnt !== 8'd0 || err_beat !== 8'd0 || err_data !== 128'd0) begin
      tests_failed++;
      $display("FAIL mid_reset got arv %b rdy %b done %b pass %b tmo %b cnt %0d beat %0d want all zero",
               axi.arvalid, axi.rready, done, pass, timeout, err_cnt, err_beat);
    end
    rst = 1'b0;
    set_clean(); run_model();
    drive_burst(1, ar_ok, rdy_ok, lat_ok);
    tests_run++; if (!ar_ok || !rdy_ok || !lat_ok || pass !== 1'b1 || err_cnt !== 8'd0) begin tests_failed++; $display("FAIL mid_restart got pass %b cnt %0d hs %b%b%b want pass 1 cnt 0 hs 111", pass, err_cnt, ar_ok, rdy_ok, lat_ok); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_directed_faults();
    test_random();
    test_timeout();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ddr_ctr_rd_test.md
Name: ddr_ctr_rd_test

Overview:
AXI4 read-channel initiator that checks DDR contents after the write test has run. Once the controller reports ddr_ready, it issues one read burst at a fixed base address and accepts every R beat. Each beat is compared against a deterministic expected pattern, and the block reports pass/fail, an error count, and the first mismatching beat. It sits beside the DDR write tester on the controller's AXI slave port; its results drive debug LEDs and the probe interface.

Parameters:
BASE_ADDR, 32'h0000_F000, byte address driven on araddr
BURST_LEN, 4, beats per burst (1..256); arlen = BURST_LEN-1
PATTERN, 128'h0000_0000_0000_0000_1234_5678_8765_4321, expected data for beat 0
TIMEOUT, 1024, maximum cycles without a handshake before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ddr_ready  in  1  DDR controller calibrated and ready
araddr  out  32  read address, constant BASE_ADDR
arlen  out  8  BURST_LEN-1
arsize  out  3  constant 3'b100 (16 bytes)
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  address valid
arready  in  1  address accepted
rdata  in  128  read data
rresp  in  2  read response
rlast  in  1  last beat marker
rvalid  in  1  read data valid
rready  out  1  read data ready
done  out  1  test finished (sticky until reset)
pass  out  1  valid when done; 1 means no errors
timeout  out  1  sticky; set when aborted by timeout
err_cnt  out  8  saturating count of erroneous beats
err_beat  out  8  index of the first erroneous beat
err_data  out  128  rdata captured on the first erroneous beat

Behaviour:
- Reset values: arvalid=0, rready=0, done=0, pass=0, timeout=0, err_cnt=0, err_beat=0, err_data=0. State returns to IDLE; the beat counter and timer clear. Reset mid-burst abandons the burst; no attempt is made to drain the R channel.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: when ddr_ready=1, set arvalid=1 on the next edge and go to ADDR.
- ADDR: hold arvalid until arvalid&arready. On the handshake edge: arvalid<=0, rready<=1, beat<=0, go to DATA.
- DATA: rready stays 1. On each rvalid&rready, compare against:
  - expected = PATTERN + beat, as a 128-bit modular add.
  - A beat is in error if rdata≠expected, or rresp≠2'b00, or rlast≠(beat==BURST_LEN-1).
  - Errors are counted once per beat; err_cnt saturates at 255.
  - err_beat and err_data are captured only when err_cnt==0 before the increment.
  - beat increments after every accepted beat.
- Leaving DATA: on an accepted beat with rlast=1, or with beat==BURST_LEN-1, whichever comes first, set rready<=0 and go to DONE. An early rlast therefore ends the test with at least one error.
- Timer: clears on every handshake and on entry to ADDR/DATA, and increments in ADDR and DATA. When it reaches TIMEOUT-1:
  - set timeout<=1 and go to DONE;
  - drop arvalid and rready;
  - pass stays 0.
- DONE: done<=1 and pass<=(err_cnt==0 && !timeout), both computed from the final values. Outputs hold until rst.
- ddr_ready deasserting after IDLE has no effect.
- Zero-wait-state slave: address-to-first-beat overhead is 2 cycles. A burst of N beats with rvalid held high completes in N cycles; done rises 1 cycle after the last beat.

Optional Feature:
Macro DDR_RD_TEST_LOOP_EN.
- Defined: DONE returns to ADDR after 16 idle cycles, repeating the burst indefinitely.
  - An extra output iter_cnt[15:0] (reset 0, wraps) increments on each completed burst.
  - pass becomes sticky-low: any failing iteration clears it permanently.
  - err_cnt accumulates across iterations; err_beat and err_data keep the first error ever seen.
  - done pulses for 1 cycle per iteration.
- Undefined: single burst as described above; iter_cnt port absent.

Decomposition:
- Shared package ddr_test_pkg:
  - AXI constants: AXSIZE_16B, BURST_INCR, RESP_OKAY.
  - FSM state enum.
  - Default PATTERN and BASE_ADDR, also used by ddr_ctr_wr_test.
- One sub-module, ddr_rd_beat_checker: combinational expected-data generation plus registered compare/capture of err_cnt, err_beat and err_data. The FSM stays in the top module.

Test Plan:
- Normal burst: BURST_LEN=4, slave returns PATTERN+0..3, rresp=0, rlast on beat 3 -> done=1, pass=1, err_cnt=0, done 1 cycle after beat 3.
- Data mismatch: beat 2 returns 128'h0 -> err_cnt=1, err_beat=2, err_data=0, pass=0.
- Bad response: rresp=2'b10 on beat 0, data correct -> err_cnt=1, err_beat=0, pass=0.
- Early rlast: rlast on beat 1 of 4 -> FSM exits after 2 beats, err_cnt=1, err_beat=1, pass=0.
- Timeout: arready never asserted, TIMEOUT=32 -> timeout=1, done=1, pass=0, arvalid=0 after 32 cycles.
- Reset mid-DATA: assert rst after beat 1 -> all outputs at reset values next cycle; ddr_ready=1 restarts the test, which completes with pass=1.
